// File: rtl/ring_router_gateway_mux_n_pkg.sv
// ring_router_gateway_mux_n_pkg: debug flit type, mux FSM states and wrapped priority search
package ring_router_gateway_mux_n_pkg;
  localparam int DII_DATA_W = 16;
  localparam int MAX_CHANNELS = 16;
  typedef struct packed {
    logic                  valid;
    logic                  last;
    logic [DII_DATA_W-1:0] data;
  } dii_flit;
  typedef enum logic {ST_IDLE, ST_LOCKED} mux_state_e;
  function automatic logic [4:0] dii_rr_next(input logic [MAX_CHANNELS-1:0] req, input logic [3:0] ptr, input int n);
    logic [4:0] r;
    int idx;
    r = '0;
    for (int i = MAX_CHANNELS; i >= 1; i--) begin
      idx = (int'(ptr) + i) % n;
      if (i <= n && req[idx]) r = {1'b1, idx[3:0]};
    end
    return r;
  endfunction
endpackage

// File: rtl/ring_router_gateway_mux_n_if.sv
// ring_router_gateway_mux_n_if: flit inputs, muxed output and grant status of the gateway mux
interface ring_router_gateway_mux_n_if #(
  parameter int CHANNELS = 3,
  localparam int GW = $clog2(CHANNELS)
) ();
  import ring_router_gateway_mux_n_pkg::*;
  dii_flit [CHANNELS-1:0] in_flit;
  logic [CHANNELS-1:0] in_ready;
  dii_flit out_flit;
  logic out_ready;
  logic [GW-1:0] grant;
  logic grant_valid;
  modport master (output in_flit, input in_ready, input out_flit, output out_ready, input grant, input grant_valid);
  modport slave (input in_flit, output in_ready, output out_flit, input out_ready, output grant, output grant_valid);
endinterface

// File: rtl/ring_router_gateway_mux_n_worm_arbiter.sv
// ring_router_worm_arbiter: combinational fixed-priority or round-robin winner pick
module ring_router_worm_arbiter
  import ring_router_gateway_mux_n_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int ROUND_ROBIN = 0,
  localparam int GW = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [GW-1:0]       ptr,
  output logic [GW-1:0]       win,
  output logic                win_valid
);
  logic [4:0] res;
  assign res = dii_rr_next(16'(req), (ROUND_ROBIN != 0) ? 4'(ptr) : 4'(CHANNELS - 1), CHANNELS);
  assign win_valid = res[4];
  assign win = GW'(res[3:0]);
endmodule

// File: rtl/ring_router_gateway_mux_n.sv
// ring_router_gateway_mux_n: worm-preserving N-input debug flit mux with grant locking
module ring_router_gateway_mux_n
  import ring_router_gateway_mux_n_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int ROUND_ROBIN = 0,
  parameter int OUT_REG = 0,
  localparam int GW = $clog2(CHANNELS)
) (
  input logic clk,
  input logic rst,
  ring_router_gateway_mux_n_if.slave bus
);
  mux_state_e state, state_nx;
  logic [GW-1:0] lock_g, rr_ptr, win, sel;
  logic [CHANNELS-1:0] req;
  logic win_valid, sel_valid, stage_ready, accept, mid;
  dii_flit picked, stage_in;
  // request vector is just the per-channel valid bits
  always_comb begin
    req = '0;
    for (int i = 0; i < CHANNELS; i++) req[i] = bus.in_flit[i].valid;
  end
  ring_router_worm_arbiter #(.CHANNELS(CHANNELS), .ROUND_ROBIN(ROUND_ROBIN)) u_arb (
    .req(req), .ptr(rr_ptr), .win(win), .win_valid(win_valid)
  );
  // state, locked grant, mid-worm flag and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      lock_g <= '0;
      mid <= 1'b0;
      rr_ptr <= GW'(CHANNELS - 1);
    end else begin
      state <= state_nx;
      if (state == ST_IDLE) lock_g <= win;
      if (accept) mid <= !stage_in.last;
      if (accept && !mid) rr_ptr <= sel;
    end
  end
  // lock whenever a presented flit does not close its worm; release on the last flit
  always_comb begin
    state_nx = (accept && stage_in.last) ? ST_IDLE : (sel_valid ? ST_LOCKED : state);
  end
  // route the selected channel into the stage, zeroing payload on bubbles
  always_comb begin
    sel_valid = !rst && (state == ST_LOCKED || win_valid);
    sel = (state == ST_LOCKED) ? lock_g : win;
    picked = bus.in_flit[sel];
    stage_in = (sel_valid && picked.valid) ? picked : '0;
    accept = stage_in.valid && stage_ready;
    bus.in_ready = (sel_valid && stage_ready) ? (CHANNELS'(1) << sel) : '0;
    bus.grant = sel_valid ? sel : '0;
    bus.grant_valid = sel_valid;
  end
  if (OUT_REG != 0) begin : g_reg
    dii_flit out_q;
    // skid-free stage: refills whenever empty or being drained this cycle
    always_ff @(posedge clk) begin
      if (rst) out_q <= '0;
      else if (stage_ready) out_q <= stage_in;
    end
    assign stage_ready = !out_q.valid || bus.out_ready;
    assign bus.out_flit = out_q;
  end else begin : g_comb
    assign stage_ready = bus.out_ready;
    assign bus.out_flit = stage_in;
  end
endmodule

// File: doc/ring_router_gateway_mux_n.md
Name: ring_router_gateway_mux_n

Overview:
- N-input, worm-preserving flit multiplexer for the debug ring gateway. It is the parametrised successor of the fixed 3-input ring/local/ext mux.
- Arbitrates between CHANNELS dii_flit sources and forwards whole worms (first flit up to and including the flit with last=1) to one output without interleaving.
- Adds selectable fixed-priority or round-robin arbitration, grant locking while the output is stalled, and an optional full-throughput output register.
- Sits in front of the ring-router egress; it also serves any node that merges more than two debug streams.

Parameters:
- CHANNELS, 3, number of inputs (2..16); index 0 is the highest fixed priority.
- ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins); 1 = round robin across worms.
- OUT_REG, 0, 0 = combinational output path (zero latency); 1 = one pipeline register stage, with full throughput.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_flit  in  CHANNELS x dii_flit  input flits (valid, last, data)
- in_ready  out  CHANNELS  per-input accept
- out_flit  out  dii_flit  muxed output flit
- out_ready  in  1  downstream accept
- grant  out  $clog2(CHANNELS)  channel currently selected; meaningful when grant_valid=1
- grant_valid  out  1  a channel is selected (IDLE with any valid input, or LOCKED)

Behaviour:
- Interface:
  - Only clk and rst. Reset is synchronous and active-high (rst sampled on posedge clk).
  - Transfer on an input or the output = valid & ready in the same cycle.
- Outputs:
  - out_flit.data and out_flit.last are driven 0 whenever out_flit.valid=0 (no X on outputs).
  - in_ready is 0 for every non-granted channel.
- Reset values:
  - state = IDLE, all in_ready = 0, out_flit = 0, grant_valid = 0, grant = 0.
  - Round-robin pointer = CHANNELS-1, so channel 0 wins first.
  - Output register empty.
- State machine, states IDLE and LOCKED(g):
  - IDLE:
    - g = arbitration winner among channels with valid=1.
    - Fixed priority: the lowest valid index wins.
    - Round robin: the first valid index searching from pointer+1 upward, wrapping modulo CHANNELS.
    - No valid input: grant_valid=0 and state is held.
  - Grant presentation: in_ready[g] = stage_ready, and the stage input is in_flit[g].
    - stage_ready = out_ready when OUT_REG=0.
    - stage_ready = !reg_full | out_ready when OUT_REG=1.
  - IDLE -> LOCKED(g) when the first flit is presented but (not accepted, or accepted with last=0).
    - This locks the grant across stalls: a higher-priority valid arriving later cannot pre-empt a presented flit.
  - IDLE stays IDLE when the presented flit is accepted with last=1 (single-flit worm).
  - LOCKED(g):
    - Only channel g is forwarded, and in_ready[g] = stage_ready.
    - Bubbles (in valid=0) are passed through as output valid=0; the lock is held.
    - LOCKED -> IDLE on acceptance of the flit with last=1.
- Round-robin pointer:
  - Updated to g in the cycle the first flit of a worm is accepted.
  - Never changes mid-worm.
  - Unused when ROUND_ROBIN=0.
- Latency:
  - OUT_REG=0: 0 cycles, and out_flit.valid is combinational from in_flit.
  - OUT_REG=1: 1 cycle. Back-to-back flits sustain 1 flit/cycle while out_ready=1.
  - OUT_REG=1: the register holds its flit stable while out_ready=0.
  - OUT_REG=1: arbitration and locking act on acceptance into the register, not on output acceptance.
- Boundaries:
  - Simultaneous valid on all channels: exactly one grant, and only that in_ready can be 1.
  - A worm of 1 flit never enters LOCKED.
  - rst mid-worm: the worm is abandoned, the register is flushed, and the FSM is in IDLE on the next cycle. The source is responsible for resynchronising.
  - CHANNELS not a power of 2: the pointer wraps from CHANNELS-1 to 0, and indices >= CHANNELS are never granted.

Decomposition:
- dii_package:
  - Reuses dii_flit.
  - Adds the function dii_rr_next(req, ptr, n) for the wrapped priority search, shared with future arbiters.
- Sub-module ring_router_worm_arbiter:
  - Takes the request vector, the ROUND_ROBIN mode and the pointer.
  - Returns the winner index plus a valid bit; purely combinational.
  - The FSM, lock and output register stay in the top module.

Test Plan:
- Fixed priority, CHANNELS=3, ch1 and ch2 valid single flits (data 0x1111, 0x2222), out_ready=1 -> output 0x1111 then 0x2222 on consecutive cycles; in_ready[2]=0 in the first cycle.
- Worm lock: ch2 sends a 3-flit worm (0xA0, 0xA1, 0xA2 last); ch0 asserts valid at flit 2 -> output A0, A1, A2 uninterrupted, then ch0's flit; grant stays 2 for 3 accepts.
- Stall lock: ch1 presents 0xB0 with out_ready=0 for 4 cycles; ch0 becomes valid at cycle 2 -> out_flit holds 0xB0 with valid=1 throughout, grant=1; 0xB0 is accepted when out_ready rises.
- Round robin, ROUND_ROBIN=1, CHANNELS=4, all channels continuously valid with single-flit worms -> grant sequence 0,1,2,3,0,1.
- OUT_REG=1, ch0 sends 8-flit worm, out_ready=1 except low in cycle 4 -> first output 1 cycle after the input, 8 flits in order, no loss or duplication, 1 flit/cycle outside the stall.
- Reset mid-worm: rst pulsed after flit 2 of 4 on ch1 -> next cycle grant_valid=0, out valid=0, FSM in IDLE, register empty; ch2's pending flit is then granted.
